bus_ram_ctrl: RTL

BUS_RAM_CTRL -- requirements
Module: bus_ram_ctrl

---
 rtl/bus_ram_pkg.sv | 25 ++
 rtl/bus_ram_ctrl_ram_core.sv | 25 ++
 rtl/bus_ram_ctrl.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/bus_ram_pkg.sv
// Shared types and constants for the bus_ram_ctrl slice.
// Define BUS_RAM_CLEAR_EN to add the post-reset CLEAR sweep state.
package bus_ram_pkg;

    localparam int DATA_W_DEF = 4;
    localparam int ADDR_W_DEF = 4;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_FILL  = 2'b10;
    localparam logic [1:0] OP_NOP   = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
`ifdef BUS_RAM_CLEAR_EN
        ST_FILL,
        ST_CLEAR
`else
        ST_FILL
`endif
    } state_t;

endpackage

// File: rtl/bus_ram_ctrl_ram_core.sv
// ram_core: single-port RAM, synchronous write, registered read.
// Contents are never reset; only writes change them.
module ram_core #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic              en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= din;
        end else if (en) begin
            q <= mem[addr];
        end
    end

endmodule

// File: rtl/bus_ram_ctrl.sv
// bus_ram_ctrl: request FSM, sweep counter and display registers.
// BUS_RAM_CLEAR_EN enables the zeroing sweep after reset release.
module bus_ram_ctrl
    import bus_ram_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              CLK100MHZ,
    input  logic              reset,
    input  logic              req,
    input  logic [1:0]        op,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ready,
    output logic              rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] last_addr,
    output logic [DATA_W-1:0] last_data
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] CNT_END = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);
`ifdef BUS_RAM_CLEAR_EN
    localparam state_t ST_RESET = ST_CLEAR;
`else
    localparam state_t ST_RESET = ST_IDLE;
`endif

    state_t state, state_n;

    logic [ADDR_W:0]   cnt, cnt_n;
    logic              sweep, sweep_done;
    logic              accept;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] fill_q;
    logic [DATA_W-1:0] rdata_q;
    logic              ram_we, ram_en;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din, ram_q;

    assign accept     = req & ready;
    assign cnt_n      = cnt + CNT_ONE;
    assign sweep_done = (cnt_n == CNT_END);

    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            state <= ST_RESET;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n  = state;
        sweep    = 1'b0;
        ram_we   = 1'b0;
        ram_en   = 1'b0;
        ram_addr = addr;
        ram_din  = wdata;
        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    unique case (1'b1)
                        op == OP_READ: begin
                            ram_en  = 1'b1;
                            state_n = ST_READ;
                        end
                        op == OP_WRITE: begin
                            ram_we  = 1'b1;
                            state_n = ST_WRITE;
                        end
                        op == OP_FILL: begin
                            state_n = ST_FILL;
                        end
                        default: begin
                            state_n = ST_IDLE;
                        end
                    endcase
                end
            end
            ST_READ, ST_WRITE: begin
                state_n = ST_IDLE;
            end
            ST_FILL: begin
                sweep    = 1'b1;
                ram_we   = 1'b1;
                ram_addr = cnt[ADDR_W-1:0];
                ram_din  = fill_q;
                if (sweep_done) begin
                    state_n = ST_IDLE;
                end
            end
`ifdef BUS_RAM_CLEAR_EN
            ST_CLEAR: begin
                sweep    = 1'b1;
                ram_we   = 1'b1;
                ram_addr = cnt[ADDR_W-1:0];
                ram_din  = '0;
                if (sweep_done) begin
                    state_n = ST_IDLE;
                end
            end
`endif
            default: begin
                state_n = ST_IDLE;
            end
        endcase
        // No memory writes while reset is held.
        if (reset) begin
            ram_we = 1'b0;
        end
    end

    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            ready     <= 1'b0;
            cnt       <= '0;
            addr_q    <= '0;
            fill_q    <= '0;
            rdata_q   <= '0;
            last_addr <= '0;
            last_data <= '0;
        end else begin
            ready <= (state_n == ST_IDLE);
            if (sweep) begin
                cnt <= sweep_done ? '0 : cnt_n;
            end
            if (state == ST_IDLE && accept) begin
                if (op == OP_READ) begin
                    addr_q <= addr;
                end
                if (op == OP_WRITE) begin
                    last_addr <= addr;
                    last_data <= wdata;
                end
                if (op == OP_FILL) begin
                    fill_q <= wdata;
                end
            end
            if (state == ST_READ) begin
                rdata_q   <= ram_q;
                last_addr <= addr_q;
                last_data <= ram_q;
            end
        end
    end

    assign rvalid = (state == ST_READ);
    assign rdata  = rvalid ? ram_q : rdata_q;

    ram_core #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk (CLK100MHZ),
        .we  (ram_we),
        .en  (ram_en),
        .addr(ram_addr),
        .din (ram_din),
        .q   (ram_q)
    );

endmodule
